// File: rtl/avalon_sdr_responder.sv
// avalon_sdr_responder: 16-bit Avalon-MM responder over a 32-bit word bank.
// Optional error capture is enabled with macro AVALON_SDR_RESP_ERRCHK_EN.
module avalon_sdr_responder #(
  parameter int          NWORDS       = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2,
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          avs_s0_read,
  input  logic          avs_s0_write,
  input  logic [31:0]   avs_s0_address,
  input  logic [15:0]   avs_s0_writedata,
  input  logic [1:0]    avs_s0_byteenable,
  output logic [15:0]   avs_s0_readdata,
  output logic          avs_s0_readdatavalid,
  output logic          avs_s0_waitrequest,
  input  logic [AW-1:0] lcl_addr,
  input  logic          lcl_rd,
  output logic [31:0]   lcl_rdata,
  input  logic          lcl_we,
  input  logic [31:0]   lcl_wdata,
`ifdef AVALON_SDR_RESP_ERRCHK_EN
  input  logic          err_clr,
  output logic          err_sticky,
  output logic [2:0]    err_code,
`endif
  output logic          lcl_collision
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [31:0]   mem [NWORDS];

  logic [31:0]   off;
  logic          in_rng;
  logic          ok;
  logic [AW-1:0] widx;
  logic          half;
  logic          cmd;
  logic          acc;
  logic          rd_acc;
  logic          av_we;
  logic          lcl_ok;
  logic          collide;
  logic [15:0]   rd_half;

  logic [READ_LATENCY-1:0] pv;
  logic [15:0]             pd [READ_LATENCY];

  assign off     = avs_s0_address - BASE_ADDR;
  assign in_rng  = off < 32'(4 * NWORDS);
  assign ok      = in_rng & ~off[0];
  assign widx    = off[AW+1:2];
  assign half    = off[1];
  assign cmd     = avs_s0_read | avs_s0_write;
  assign acc     = cmd & ~avs_s0_waitrequest;
  assign rd_acc  = acc & avs_s0_read & ~avs_s0_write;
  assign av_we   = acc & avs_s0_write & ok;
  assign lcl_ok  = 32'(lcl_addr) < 32'(NWORDS);
  assign collide = lcl_we & av_we & (widx == lcl_addr);
  assign rd_half = !ok  ? 16'h0000 :
                   half ? mem[widx][31:16] : mem[widx][15:0];

  // Stall decision: live on wcnt so the accept cycle needs no extra register
  always_comb begin
    avs_s0_waitrequest = 1'b1;
    if (reset)
      avs_s0_waitrequest = 1'b1;
    else if (state == STALL)
      avs_s0_waitrequest = (wcnt != WW'(WAIT_CYCLES));
    else
      avs_s0_waitrequest = (WAIT_CYCLES != 0);
  end

  // Stall FSM: every new command pays WAIT_CYCLES before acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd && WAIT_CYCLES != 0) begin
            state <= STALL;
            wcnt  <= WW'(1);
          end
        end
        STALL: begin
          if (!cmd || !avs_s0_waitrequest) begin
            state <= IDLE;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
      endcase
    end
  end

  // Bank writes: Avalon byte lanes win over a same-word local write
  always_ff @(posedge clk) begin
    if (av_we) begin
      if (avs_s0_byteenable[0])
        mem[widx][{half, 4'd0} +: 8] <= avs_s0_writedata[7:0];
      if (avs_s0_byteenable[1])
        mem[widx][{half, 4'd8} +: 8] <= avs_s0_writedata[15:8];
    end
    if (lcl_we && lcl_ok && !collide)
      mem[lcl_addr] <= lcl_wdata;
  end

  // Local read port and dropped-write pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      lcl_rdata     <= '0;
      lcl_collision <= 1'b0;
    end else begin
      lcl_collision <= collide;
      if (lcl_rd)
        lcl_rdata <= lcl_ok ? mem[lcl_addr] : 32'h0;
    end
  end

  // Read return pipe: data captured at acceptance, zero when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      pd[0] <= rd_acc ? rd_half : 16'h0000;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign avs_s0_readdatavalid = pv[READ_LATENCY-1];
  assign avs_s0_readdata      = pd[READ_LATENCY-1];

`ifdef AVALON_SDR_RESP_ERRCHK_EN
  logic [2:0] err_now;

  assign err_now = {acc & avs_s0_read & avs_s0_write,
                    acc & ~in_rng,
                    acc & avs_s0_address[0]};

  // Error capture: bits accumulate until cleared
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      err_code   <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_code <= err_code | err_now;
      if (|err_now)
        err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/avalon_sdr_responder.md
Name: avalon_sdr_responder

Overview:
Avalon-MM responder (slave) with a 16-bit data bus, backed by an internal bank of 32-bit words. It is the far end of the 16-bit SDR master used by the raytracer: the master issues halfword reads and writes, and this block stalls them with waitrequest and returns read data with a fixed pipelined latency. It serves as the SDRAM stand-in for simulation and as an on-chip scene/result buffer. A 32-bit local port gives the compute core direct word access.

Parameters:
NWORDS, 64, number of 32-bit words in the bank; byte span is 4*NWORDS.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
WAIT_CYCLES, 1, waitrequest cycles inserted before each command is accepted; 0 means never stall.
READ_LATENCY, 2, cycles from read acceptance to readdatavalid; must be 1 to 8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
avs_s0_read  in  1  read request
avs_s0_write  in  1  write request
avs_s0_address  in  32  byte address
avs_s0_writedata  in  16  write halfword
avs_s0_byteenable  in  2  byte lanes
avs_s0_readdata  out  16  read halfword
avs_s0_readdatavalid  out  1  read data valid
avs_s0_waitrequest  out  1  stall
lcl_addr  in  clog2(NWORDS)  local word index
lcl_rd  in  1  local read strobe
lcl_rdata  out  32  local read data, valid the cycle after lcl_rd
lcl_we  in  1  local write strobe
lcl_wdata  in  32  local write word
lcl_collision  out  1  one-cycle pulse: local write dropped

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Memory contents are not reset.
- Reset values:
  - readdatavalid = 0, readdata = 0, lcl_rdata = 0, lcl_collision = 0.
  - The read pipeline is flushed; reads accepted before reset never return.
  - waitrequest = 1 while reset is high.
- Decode:
  - off = address - BASE_ADDR (32-bit unsigned).
  - word = off >> 2; half = off[1].
  - half = 0 selects bits [15:0]; half = 1 selects bits [31:16] (little-endian).
  - In range when off < 4*NWORDS.
- Stall FSM, states IDLE and STALL, with counter wcnt (width clog2(WAIT_CYCLES+1)):
  - IDLE: if (read|write) and WAIT_CYCLES>0, go to STALL with wcnt=1 and waitrequest=1. If WAIT_CYCLES=0, accept the command in the same cycle.
  - STALL: waitrequest = (wcnt != WAIT_CYCLES), combinational on wcnt. wcnt increments each cycle. When waitrequest=0, the command is accepted and the FSM returns to IDLE.
  - If read and write both drop while in STALL, return to IDLE with no side effect.
  - Back-to-back commands each pay WAIT_CYCLES stall cycles.
- Accepted write:
  - byteenable[0] writes writedata[7:0] into the selected half's low byte.
  - byteenable[1] writes writedata[15:8] into the selected half's high byte.
  - Out of range, or address[0]=1: no write.
- Accepted read:
  - The selected halfword is sampled at acceptance and enters a READ_LATENCY-deep shift pipeline.
  - readdatavalid is high exactly READ_LATENCY cycles after acceptance, for one cycle.
  - Out of range or address[0]=1 returns 16'h0000, still with readdatavalid.
  - Reads pipeline fully: one acceptance per command, with no limit on outstanding reads beyond the pipe depth.
  - readdata = 0 whenever readdatavalid = 0.
- read and write asserted together: handled as a write only; no read response.
- Read-after-write: a read accepted on the cycle after a write to the same halfword returns the new data.
- Local port:
  - lcl_rd registers mem[lcl_addr] into lcl_rdata (1-cycle latency); lcl_rdata holds otherwise.
  - lcl_we writes the full word.
  - If an Avalon write is accepted to the same word in the same cycle, the Avalon write wins, the local write is dropped, and lcl_collision pulses.
  - A local write to a different word proceeds in parallel.
  - A local read in the same cycle as a write to the same word returns the old data.

Optional Feature:
Macro AVALON_SDR_RESP_ERRCHK_EN.
- Defined: adds ports err_sticky (out, 1) and err_code (out, 3), plus input err_clr.
- err_code is set on the first error; err_sticky stays set until err_clr or reset.
  - bit0: misaligned access.
  - bit1: out of range.
  - bit2: read and write asserted together.
  - An error whose bit is already set does not change err_code.
- Not defined: no ports, no logic. Data-path behaviour is identical in both builds.

Test Plan:
- WAIT_CYCLES=1, READ_LATENCY=2. Write 16'hBEEF at 0x0, then 16'hDEAD at 0x2 -> each write sees 1 waitrequest cycle; lcl_rd of word 0 gives 32'hDEADBEEF.
- lcl_we word 3 = 32'h12345678. Avalon reads at 0xC and 0xE -> readdatavalid exactly 2 cycles after each acceptance; data 16'h5678, then 16'h1234.
- Write 16'hAB12 at 0x4 with byteenable=2'b10 over existing 16'hFFFF -> reading 0x4 returns 16'hABFF.
- Read at 4*NWORDS, and read at 0x1 -> both return 16'h0000 with valid; with ERRCHK, err_code = 3'b011.
- Same cycle: Avalon write accepted to word 2 and lcl_we to word 2 -> Avalon data stored, lcl_collision = 1 for one cycle.
- Accept 2 pipelined reads, then assert reset for 1 cycle -> readdatavalid never asserts; waitrequest = 1 during reset.
